hashed_tag_lookup: RTL and testbench

- Parametrised successor to the fixed 32-to-6-bit instruction address hasher.
- Folds an instruction fetch address into an INDEX_W-bit set index and holds a direct-mapped tag/valid store at that index.
- Answers hit/miss lookups through a valid/ready handshake, accepts line fills, and clears all valid bits with a multi-cycle sweep.
- Sits between the fetch unit and the instruction cache data array.

---
 rtl/hashed_tag_lookup.sv | 156 +++++++++++++++
 tb/tb_hashed_tag_lookup.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hashed_tag_lookup.sv
// Direct-mapped tag/valid store indexed by an XOR-folded fetch address, with a
// valid/ready lookup port, line fills and an invalidate-all sweep.
// Optional hit/miss counters: define HASHED_TAG_LOOKUP_STATS_EN.
module hashed_tag_lookup #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [INDEX_W-1:0] resp_index,
  input  logic               fill_valid,
  input  logic [ADDR_W-1:0]  fill_addr,
  input  logic               inv_start,
  output logic               busy
`ifdef HASHED_TAG_LOOKUP_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned DEPTH  = 2 ** INDEX_W;

  typedef enum logic [0:0] {StSweep, StIdle} stateE;

  // XOR of zero-padded INDEX_W-bit slices: bit i of the word lands on bit i mod INDEX_W.
  function automatic logic [INDEX_W-1:0] hashWord(input logic [WORD_W-1:0] word);
    logic [INDEX_W-1:0] h;
    h = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      h[i % INDEX_W] ^= word[i];
    end
    return h;
  endfunction

  stateE              stateQ, stateD;
  logic [INDEX_W-1:0] cntQ, cntD;
  logic [DEPTH-1:0]   validQ;
  logic [WORD_W-1:0]  tagQ [DEPTH];
  logic               respValidQ, respHitQ;
  logic [INDEX_W-1:0] respIndexQ;

  logic               clrEn, fillEn, accept, lookupHit;
  logic [WORD_W-1:0]  reqWord, fillWord;
  logic [INDEX_W-1:0] reqIdx, fillIdx;
  logic               unusedAddrBits;

  assign reqWord        = req_addr[ADDR_W-1:2];
  assign fillWord       = fill_addr[ADDR_W-1:2];
  assign reqIdx         = hashWord(reqWord);
  assign fillIdx        = hashWord(fillWord);
  assign unusedAddrBits = ^{req_addr[1:0], fill_addr[1:0]};

  // Read-before-write: the lookup compares against contents before this cycle's fill.
  assign lookupHit = validQ[reqIdx] && (tagQ[reqIdx] == reqWord);
  assign accept    = req_valid && req_ready;

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    req_ready = 1'b0;
    busy      = 1'b0;
    clrEn     = 1'b0;
    fillEn    = 1'b0;
    unique case (stateQ)
      StSweep: begin
        busy  = 1'b1;
        clrEn = !rst;
        if (inv_start) begin
          cntD = '0;
        end else begin
          cntD = cntQ + 1'b1;
          if (&cntQ) stateD = StIdle;
        end
      end
      StIdle: begin
        if (inv_start) begin
          stateD = StSweep;
          cntD   = '0;
        end else begin
          req_ready = 1'b1;
          fillEn    = fill_valid && !rst;
        end
      end
      default: stateD = StSweep;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StSweep;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Valid bits rely on the post-reset sweep rather than a reset branch.
  always_ff @(posedge clk) begin
    if (clrEn) begin
      validQ[cntQ] <= 1'b0;
    end else if (fillEn) begin
      validQ[fillIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fillEn) tagQ[fillIdx] <= fillWord;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      respValidQ <= 1'b0;
      respHitQ   <= 1'b0;
      respIndexQ <= '0;
    end else begin
      respValidQ <= accept;
      if (accept) begin
        respHitQ   <= lookupHit;
        respIndexQ <= reqIdx;
      end
    end
  end

  assign resp_valid = respValidQ;
  assign resp_hit   = respHitQ;
  assign resp_index = respIndexQ;

`ifdef HASHED_TAG_LOOKUP_STATS_EN
  logic [15:0] hitCntQ, missCntQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      hitCntQ  <= '0;
      missCntQ <= '0;
    end else if (respValidQ) begin
      if (respHitQ) begin
        if (hitCntQ != 16'hFFFF) hitCntQ <= hitCntQ + 16'd1;
      end else begin
        if (missCntQ != 16'hFFFF) missCntQ <= missCntQ + 16'd1;
      end
    end
  end

  assign hit_count  = hitCntQ;
  assign miss_count = missCntQ;
`endif

endmodule

// File: tb/tb_hashed_tag_lookup.sv
// Directed bench for hashed_tag_lookup with hand-computed expected values.
module tb_hashed_tag_lookup;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, resp_valid, resp_hit;
  logic [31:0] req_addr, fill_addr;
  logic [5:0]  resp_index;
  logic        fill_valid, inv_start, busy;
`ifdef HASHED_TAG_LOOKUP_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int unsigned nChecks = 0;
  int unsigned nFails  = 0;
  int          n, bad;

  always #5 clk = ~clk;

  hashed_tag_lookup #(.ADDR_W(32), .INDEX_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_index (resp_index),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .inv_start  (inv_start),
    .busy       (busy)
`ifdef HASHED_TAG_LOOKUP_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doFill(input logic [31:0] addr);
    fill_valid = 1'b1;
    fill_addr  = addr;
    tick();
    fill_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] addr, input logic expHit,
                        input logic [5:0] expIdx);
    req_valid = 1'b1;
    req_addr  = addr;
    checkVal({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    checkVal({tag, ".valid"}, {31'd0, resp_valid}, 32'd1);
    checkVal({tag, ".hit"}, {31'd0, resp_hit}, {31'd0, expHit});
    checkVal({tag, ".index"}, {26'd0, resp_index}, {26'd0, expIdx});
  endtask

  task automatic waitIdle(input string tag, input int expCycles);
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    checkVal(tag, k, expCycles);
  endtask

  logic [31:0] b2bAddr [3] = '{32'h8, 32'h104, 32'h100};
  logic        b2bHit  [3] = '{1'b1, 1'b0, 1'b1};
  logic [5:0]  b2bIdx  [3] = '{6'd2, 6'd0, 6'd1};
  logic [31:0] sweptAddr [7] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70};
  logic [5:0]  sweptIdx  [7] = '{6'd4, 6'd8, 6'd12, 6'd16, 6'd20, 6'd24, 6'd28};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; fill_valid = 1'b0; fill_addr = '0;
    inv_start = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    req_valid = 1'b1;
    checkVal("rst.busy", {31'd0, busy}, 32'd1);
    checkVal("rst.ready", {31'd0, req_ready}, 32'd0);
    checkVal("rst.respValid", {31'd0, resp_valid}, 32'd0);
    checkVal("rst.respHit", {31'd0, resp_hit}, 32'd0);
    checkVal("rst.respIndex", {26'd0, resp_index}, 32'd0);

    // Request held high through the whole reset sweep.
    n = 0; bad = 0;
    while (busy && n < 300) begin
      n++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) bad++;
      tick();
    end
    checkVal("initSweep.len", n, 64);
    checkVal("initSweep.stalled", bad, 0);
    checkVal("initSweep.readyAfter", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    checkVal("firstResp.valid", {31'd0, resp_valid}, 32'd1);
    checkVal("firstResp.hit", {31'd0, resp_hit}, 32'd0);
    tick();

    doFill(32'h4);
    lookup("fill4", 32'h4, 1'b1, 6'd1);
    lookup("miss104", 32'h104, 1'b0, 6'd0);
    lookup("alias100", 32'h100, 1'b0, 6'd1);
    doFill(32'h100);
    lookup("alias4", 32'h4, 1'b0, 6'd1);
    lookup("hit100", 32'h100, 1'b1, 6'd1);

    // Same-cycle fill and lookup: old contents seen, new contents visible next cycle.
    fill_valid = 1'b1; fill_addr = 32'h8;
    req_valid  = 1'b1; req_addr  = 32'h8;
    tick();
    fill_valid = 1'b0; req_valid = 1'b0;
    checkVal("rbw.hit", {31'd0, resp_hit}, 32'd0);
    checkVal("rbw.index", {26'd0, resp_index}, 32'd2);
    lookup("afterFill8", 32'h8, 1'b1, 6'd2);

    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = b2bAddr[i];
      tick();
      checkVal("b2b.valid", {31'd0, resp_valid}, 32'd1);
      checkVal("b2b.hit", {31'd0, resp_hit}, {31'd0, b2bHit[i]});
      checkVal("b2b.index", {26'd0, resp_index}, {26'd0, b2bIdx[i]});
    end
    req_valid = 1'b0;
    tick();
    checkVal("pulse.valid", {31'd0, resp_valid}, 32'd0);
    checkVal("pulse.holdIndex", {26'd0, resp_index}, 32'd1);
    checkVal("pulse.holdHit", {31'd0, resp_hit}, 32'd1);

    for (int i = 0; i < 5; i++) doFill(sweptAddr[i]);
    lookup("preSweep", 32'h30, 1'b1, 6'd12);

    // Response pending when inv_start is taken is still delivered; same-cycle work dropped.
    req_valid = 1'b1; req_addr = 32'h10;
    tick();
    checkVal("pend.valid", {31'd0, resp_valid}, 32'd1);
    checkVal("pend.hit", {31'd0, resp_hit}, 32'd1);
    inv_start = 1'b1; fill_valid = 1'b1; fill_addr = 32'h70;
    #1;
    checkVal("invCycle.ready", {31'd0, req_ready}, 32'd0);
    checkVal("invCycle.busy", {31'd0, busy}, 32'd0);
    tick();
    inv_start = 1'b0; fill_valid = 1'b0; req_valid = 1'b0;
    checkVal("dropReq.valid", {31'd0, resp_valid}, 32'd0);

    n = 0; bad = 0;
    while (busy && n < 300) begin
      n++;
      if (req_ready !== 1'b0) bad++;
      if (n == 10) inv_start = 1'b1;
      if (n == 20) begin
        fill_valid = 1'b1;
        fill_addr  = 32'h60;
      end
      tick();
      inv_start  = 1'b0;
      fill_valid = 1'b0;
    end
    checkVal("restartSweep.len", n, 74);
    checkVal("restartSweep.ready", bad, 0);
    for (int i = 0; i < 7; i++) lookup("swept", sweptAddr[i], 1'b0, sweptIdx[i]);

    // Reset during an accepted lookup discards the response and restarts the sweep.
    doFill(32'h8);
    req_valid = 1'b1; req_addr = 32'h8; rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    checkVal("midRst.respValid", {31'd0, resp_valid}, 32'd0);
    checkVal("midRst.busy", {31'd0, busy}, 32'd1);
    checkVal("midRst.respIndex", {26'd0, resp_index}, 32'd0);
    waitIdle("midRst.sweepLen", 64);
`ifdef HASHED_TAG_LOOKUP_STATS_EN
    checkVal("stats.rstHit", {16'd0, hit_count}, 32'd0);
    checkVal("stats.rstMiss", {16'd0, miss_count}, 32'd0);
`endif
    lookup("midRst.cleared", 32'h8, 1'b0, 6'd2);

`ifdef HASHED_TAG_LOOKUP_STATS_EN
    doFill(32'h4);
    for (int i = 0; i < 3; i++) lookup("stats.hit", 32'h4, 1'b1, 6'd1);
    lookup("stats.miss", 32'h104, 1'b0, 6'd0);
    tick();
    checkVal("stats.hitCount", {16'd0, hit_count}, 32'd3);
    checkVal("stats.missCount", {16'd0, miss_count}, 32'd2);
    inv_start = 1'b1;
    tick();
    inv_start = 1'b0;
    waitIdle("stats.sweepLen", 64);
    checkVal("stats.invHit", {16'd0, hit_count}, 32'd3);
    checkVal("stats.invMiss", {16'd0, miss_count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("stats.clrHit", {16'd0, hit_count}, 32'd0);
    checkVal("stats.clrMiss", {16'd0, miss_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
